free_list: RTL and testbench
============================

// Module: free_list
// PURPOSE
//  Circular free list of physical register tags; sits directly upstream of the map table.
//  Supplies up to WIDTH new tags per cycle to dispatch (map table T inputs).
//  Reclaims the previous mapping (T_old) of each retiring instruction from the ROB.
//  On rollback it restores its state to the retired (architectural) point, in step with the map table reload.
// PARAMETERS
//  WIDTH     2   superscalar lanes (dispatch and retire); defaults to `WIDTH
//  RF_SIZE   32  architectural registers; defaults to `RF_SIZE
//  PRF_SIZE  64  physical registers; defaults to `PRF_SIZE
//  FL_SIZE   PRF_SIZE-RF_SIZE (32)  free-list depth; derived, must be a power of 2
// PORTS
//  clock          in   1                   single clock, posedge
//  reset          in   1                   asynchronous, active-high
//  alloc_req      in   WIDTH               lane i needs a tag; decoder never requests for ZERO_REG
//  alloc_tag      out  WIDTH x log2(PRF)   tag for lane i; feeds map table T
//  stall          out  1                   not enough free tags; no lane allocates this cycle
//  retire_en      in   WIDTH               lane i retires an instruction with a destination
//  retire_told    in   WIDTH x log2(PRF)   T_old of retiring lane i; returned to list
//  rollback_en    in   1                   recover to the retired state; same pulse as the map table
//  free_count     out  log2(FL_SIZE)+1     registered count of free tags
//  fl_error       out  1                   sticky error; present only with FREE_LIST_ERR_EN
// BEHAVIOUR
//  Storage
//   - entries[FL_SIZE] array.
//   - Pointers head, tail, rhead: each log2(FL_SIZE)+1 bits, MSB is the wrap bit.
//   - count = tail - head.
//  Reset (async)
//   - entries[i] = RF_SIZE+i; head = 0; rhead = 0; tail = FL_SIZE (wrap bit set, index 0).
//   - free_count = FL_SIZE; stall = 0; fl_error = 0.
//   - alloc_tag = 0 for every lane with alloc_req low; this holds in every cycle, not only at reset.
//  Allocate (combinational, zero latency)
//   - Lanes are packed: lane i reads entries[head + popcount(alloc_req[i-1:0])].
//   - stall = popcount(alloc_req) > count. Allocation is all-or-nothing per cycle.
//   - If !stall && !rollback_en: head advances by popcount(alloc_req) at posedge.
//  Retire (registered)
//   - Lane i with retire_en writes retire_told into entries[tail + popcount(retire_en[i-1:0])].
//   - tail advances by popcount(retire_en).
//   - rhead advances by popcount(retire_en); it tracks the oldest non-retired allocation.
//   - Tags freed in cycle N become allocatable in cycle N+1. No same-cycle bypass.
//  Rollback
//   - head <= rhead + popcount(retire_en). This returns every speculative allocation.
//   - Allocation is suppressed that cycle; stall is not asserted for it.
//   - Retire in the same cycle is still applied.
//   - Post-recovery count = FL_SIZE exactly. Invariant at all times: tail - rhead == FL_SIZE.
//  Simultaneous alloc + retire
//   - Both apply: count_next = count - alloc + retire.
//   - Retire writes only slots in [tail, head+FL_SIZE), so it never overwrites unretired entries.
//  Wrap-around
//   - All pointer arithmetic is modulo 2*FL_SIZE; the index is the low log2(FL_SIZE) bits.
//  Reset mid-operation
//   - Immediate return to the reset state; all in-flight pointer updates are dropped.
//  free_count
//   - Registered count, i.e. the value after the previous edge.
//   - Dispatch may use it for early stall; stall remains the authoritative signal.
// CONFIGURATION
//  FREE_LIST_ERR_EN defined:
//   - fl_error port exists.
//   - It sets, and holds until reset, on either condition:
//     - retire pushes with count+popcount(retire_en) > FL_SIZE (overflow);
//     - retire_told equals a tag currently held in [head, tail) (duplicate free).
//  FREE_LIST_ERR_EN undefined:
//   - Port and check logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  Shared package (sys_defs): phys_tag_t (log2 PRF_SIZE bits), fl_ptr_t, FL_SIZE constant.
//  Sub-module fl_lane_compact: WIDTH-bit mask -> per-lane prefix popcount offsets.
//   - Instantiated twice: once for alloc, once for retire.
// TESTING
//  1 Reset, alloc_req=2'b11 -> alloc_tag={33,32}; next cycle free_count=30.
//  2 alloc_req=2'b10 only -> lane1 gets 32 (packed); lane0 tag=0; free_count 32->31.
//  3 Allocate 31 tags, then alloc_req=2'b11 -> stall=1; head unchanged.
//    Same cycle retire_en=2'b01, told=5 -> next cycle count=2; alloc_req=2'b11 gives {5,63}.
//  4 Allocate 6 tags, retire 2 (told 3,4), then rollback_en -> free_count=32.
//    Next alloc_tag[0]=34, the third allocated tag.
//  5 Run past 2*FL_SIZE allocate/retire pairs -> pointers wrap.
//    Tags come out in FIFO order; count stays consistent.
//  6 Assert reset asynchronously mid-cycle during alloc -> outputs reset immediately, free_count=32.
//    With FREE_LIST_ERR_EN: retire while full -> fl_error=1 and stays 1.

Source files
------------

// File: rtl/free_list_pkg.sv
// free_list_pkg: shared sizes and types for the physical-register free list.
// Sizes come from `WIDTH, `RF_SIZE and `PRF_SIZE when defined (defaults 2/32/64).
`ifndef WIDTH
`define WIDTH 2
`endif
`ifndef RF_SIZE
`define RF_SIZE 32
`endif
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif

package free_list_pkg;
  localparam int WIDTH    = `WIDTH;
  localparam int RF_SIZE  = `RF_SIZE;
  localparam int PRF_SIZE = `PRF_SIZE;
  localparam int FL_SIZE  = PRF_SIZE - RF_SIZE;
  localparam int TAG_W    = $clog2(PRF_SIZE);
  localparam int IDX_W    = $clog2(FL_SIZE);
  localparam int PTR_W    = IDX_W + 1;

  typedef logic [TAG_W-1:0] phys_tag_t;
  // MSB is the wrap bit; low IDX_W bits index the entry array.
  typedef logic [PTR_W-1:0] fl_ptr_t;
endpackage

// File: rtl/free_list_if.sv
// free_list_if: dispatch/retire/rollback bundle between the pipeline and the free list.
// master = pipeline side, slave = free list. fl_error exists only with FREE_LIST_ERR_EN.
interface free_list_if;
  import free_list_pkg::*;

  logic [WIDTH-1:0]      alloc_req;
  phys_tag_t [WIDTH-1:0] alloc_tag;
  logic                  stall;
  logic [WIDTH-1:0]      retire_en;
  phys_tag_t [WIDTH-1:0] retire_told;
  logic                  rollback_en;
  logic [IDX_W:0]        free_count;
`ifdef FREE_LIST_ERR_EN
  logic                  fl_error;

  modport master (
    output alloc_req, retire_en, retire_told, rollback_en,
    input  alloc_tag, stall, free_count, fl_error
  );
  modport slave (
    input  alloc_req, retire_en, retire_told, rollback_en,
    output alloc_tag, stall, free_count, fl_error
  );
`else
  modport master (
    output alloc_req, retire_en, retire_told, rollback_en,
    input  alloc_tag, stall, free_count
  );
  modport slave (
    input  alloc_req, retire_en, retire_told, rollback_en,
    output alloc_tag, stall, free_count
  );
`endif
endinterface

// File: rtl/free_list_lane_compact.sv
// free_list_lane_compact: per-lane prefix popcount of a lane mask.
// Ports: mask in; offset[i] = popcount(mask[i-1:0]); total = popcount(mask).
module free_list_lane_compact
  import free_list_pkg::*;
(
  input  logic [WIDTH-1:0]    mask,
  output fl_ptr_t [WIDTH-1:0] offset,
  output fl_ptr_t             total
);

  fl_ptr_t acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc       = acc + fl_ptr_t'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list.sv
// free_list: circular free list of physical tags with retire-point rollback.
// Ports: clock, reset (async high), fl (free_list_if.slave). Option: FREE_LIST_ERR_EN.
module free_list
  import free_list_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  free_list_if.slave fl
);

  phys_tag_t entries [FL_SIZE];

  fl_ptr_t head;
  fl_ptr_t tail;
  fl_ptr_t rhead;
  fl_ptr_t count;

  fl_ptr_t [WIDTH-1:0] a_off;
  fl_ptr_t [WIDTH-1:0] r_off;
  fl_ptr_t             a_tot;
  fl_ptr_t             r_tot;
  logic                do_alloc;

  function automatic logic [IDX_W-1:0] idx(input fl_ptr_t p);
    return p[IDX_W-1:0];
  endfunction

  free_list_lane_compact u_alloc_cmp (
    .mask   (fl.alloc_req),
    .offset (a_off),
    .total  (a_tot)
  );

  free_list_lane_compact u_ret_cmp (
    .mask   (fl.retire_en),
    .offset (r_off),
    .total  (r_tot)
  );

  assign count         = tail - head;
  assign fl.free_count = count;
  // Rollback owns the cycle: no allocation and no stall.
  assign fl.stall      = !fl.rollback_en && (a_tot > count);
  assign do_alloc      = !fl.rollback_en && (a_tot <= count);

  always_comb begin
    fl.alloc_tag = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (fl.alloc_req[i]) begin
        fl.alloc_tag[i] = entries[idx(head + a_off[i])];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      rhead <= '0;
      tail  <= fl_ptr_t'(FL_SIZE);
      for (int i = 0; i < FL_SIZE; i++) begin
        entries[i] <= phys_tag_t'(RF_SIZE + i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (fl.retire_en[i]) begin
          entries[idx(tail + r_off[i])] <= fl.retire_told[i];
        end
      end
      tail  <= tail + r_tot;
      rhead <= rhead + r_tot;
      // rhead+retired is the new architectural head: drops all speculation.
      if (fl.rollback_en) begin
        head <= rhead + r_tot;
      end else if (do_alloc) begin
        head <= head + a_tot;
      end
    end
  end

`ifdef FREE_LIST_ERR_EN
  logic             err_q;
  logic             overflow;
  logic             dup;
  logic [IDX_W-1:0] rel;

  always_comb begin
    overflow = (|fl.retire_en) &&
               ((int'(count) + int'(r_tot)) > FL_SIZE);
    dup = 1'b0;
    rel = '0;
    for (int j = 0; j < FL_SIZE; j++) begin
      rel = j[IDX_W-1:0] - head[IDX_W-1:0];
      // Slot j holds a free tag when its distance from head is below count.
      if ({1'b0, rel} < count) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (fl.retire_en[i] && (fl.retire_told[i] == entries[j])) begin
            dup = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (overflow || dup) begin
      err_q <= 1'b1;
    end
  end

  assign fl.fl_error = err_q;
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed table-driven bench for free_list.
// Inputs change on negedge, outputs are checked 1 time unit later.
module tb_free_list;
  import free_list_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  free_list_if fl_if ();

  free_list dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] req;
    logic [1:0] ren;
    int         told0;
    int         told1;
    logic       rb;
    logic       stall;
    int         tag0;
    int         tag1;
    int         fc;
  } vec_t;

  vec_t vt [12];
  int   q [$];
  int   prev0;
  int   prev1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] ren,
                       input int t0, input int t1, input logic rb);
    @(negedge clock);
    fl_if.alloc_req      = req;
    fl_if.retire_en      = ren;
    fl_if.retire_told[0] = phys_tag_t'(t0);
    fl_if.retire_told[1] = phys_tag_t'(t1);
    fl_if.rollback_en    = rb;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fl_if.alloc_req   = '0;
    fl_if.retire_en   = '0;
    fl_if.rollback_en = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    fl_if.alloc_req   = '0;
    fl_if.retire_en   = '0;
    fl_if.retire_told = '0;
    fl_if.rollback_en = 1'b0;

    // reset state
    #2;
    chk("rst_fc", 32'(fl_if.free_count), 32);
    chk("rst_stall", 32'(fl_if.stall), 0);
    chk("rst_tag0", 32'(fl_if.alloc_tag[0]), 0);
`ifdef FREE_LIST_ERR_EN
    chk("rst_err", 32'(fl_if.fl_error), 0);
`endif
    @(negedge clock);
    reset = 1'b0;

    // test 1: two tags from reset, count drops to 30
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    chk("t1_tag0", 32'(fl_if.alloc_tag[0]), 32);
    chk("t1_tag1", 32'(fl_if.alloc_tag[1]), 33);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("t1_fc", 32'(fl_if.free_count), 30);
    chk("t1_tag_idle", 32'(fl_if.alloc_tag[1]), 0);

    // table: packing, retire, rollback (with and without retire)
    vt[0]  = '{2'b10, 2'b00, 0,  0, 1'b0, 1'b0, 0,  32, 32};
    vt[1]  = '{2'b00, 2'b00, 0,  0, 1'b0, 1'b0, 0,  0,  31};
    vt[2]  = '{2'b01, 2'b00, 0,  0, 1'b0, 1'b0, 33, 0,  31};
    vt[3]  = '{2'b11, 2'b00, 0,  0, 1'b0, 1'b0, 34, 35, 30};
    vt[4]  = '{2'b11, 2'b01, 3,  0, 1'b0, 1'b0, 36, 37, 28};
    vt[5]  = '{2'b00, 2'b10, 0,  4, 1'b0, 1'b0, 0,  0,  27};
    vt[6]  = '{2'b11, 2'b00, 0,  0, 1'b1, 1'b0, 38, 39, 28};
    vt[7]  = '{2'b01, 2'b00, 0,  0, 1'b0, 1'b0, 34, 0,  32};
    vt[8]  = '{2'b11, 2'b11, 10, 11, 1'b0, 1'b0, 35, 36, 31};
    vt[9]  = '{2'b11, 2'b01, 12, 0, 1'b1, 1'b0, 37, 38, 31};
    vt[10] = '{2'b11, 2'b00, 0,  0, 1'b0, 1'b0, 37, 38, 32};
    vt[11] = '{2'b00, 2'b00, 0,  0, 1'b0, 1'b0, 0,  0,  30};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].req, vt[i].ren, vt[i].told0, vt[i].told1, vt[i].rb);
      chk($sformatf("vec%0d_stall", i), 32'(fl_if.stall), 32'(vt[i].stall));
      chk($sformatf("vec%0d_tag0", i), 32'(fl_if.alloc_tag[0]), vt[i].tag0);
      chk($sformatf("vec%0d_tag1", i), 32'(fl_if.alloc_tag[1]), vt[i].tag1);
      chk($sformatf("vec%0d_fc", i), 32'(fl_if.free_count), vt[i].fc);
    end

    // test 3: drain to one tag, stall, then freed tag usable next cycle
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(2'b11, 2'b00, 0, 0, 1'b0);
      chk("t3_fill0", 32'(fl_if.alloc_tag[0]), 32'(32 + 2 * k));
      chk("t3_fill1", 32'(fl_if.alloc_tag[1]), 32'(33 + 2 * k));
    end
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    chk("t3_last", 32'(fl_if.alloc_tag[0]), 62);
    drive(2'b11, 2'b01, 5, 0, 1'b0);
    chk("t3_stall", 32'(fl_if.stall), 1);
    chk("t3_fc1", 32'(fl_if.free_count), 1);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    chk("t3_unstall", 32'(fl_if.stall), 0);
    chk("t3_fc2", 32'(fl_if.free_count), 2);
    chk("t3_tag0", 32'(fl_if.alloc_tag[0]), 63);
    chk("t3_tag1", 32'(fl_if.alloc_tag[1]), 5);
    drive(2'b01, 2'b00, 0, 0, 1'b0);
    chk("t3_empty_fc", 32'(fl_if.free_count), 0);
    chk("t3_empty_stall", 32'(fl_if.stall), 1);

    // test 5: wrap-around, FIFO order against a queue model
    do_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    for (int c = 0; c < 40; c++) begin
      if (c == 0) drive(2'b11, 2'b00, 0, 0, 1'b0);
      else        drive(2'b11, 2'b11, prev0, prev1, 1'b0);
      chk("t5_fc", 32'(fl_if.free_count), 32'(q.size()));
      chk("t5_tag0", 32'(fl_if.alloc_tag[0]), 32'(q[0]));
      chk("t5_tag1", 32'(fl_if.alloc_tag[1]), 32'(q[1]));
      if (c != 0) begin
        q.push_back(prev0);
        q.push_back(prev1);
      end
      prev0 = q.pop_front();
      prev1 = q.pop_front();
    end
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("t5_fc_end", 32'(fl_if.free_count), 30);

    // test 6: asynchronous reset in the middle of an allocation cycle
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_fc", 32'(fl_if.free_count), 32);
    chk("t6_stall", 32'(fl_if.stall), 0);
    chk("t6_tag0", 32'(fl_if.alloc_tag[0]), 32);
    chk("t6_tag1", 32'(fl_if.alloc_tag[1]), 33);
    @(negedge clock);
    reset = 1'b0;

`ifdef FREE_LIST_ERR_EN
    drive(2'b00, 2'b01, 7, 0, 1'b0);
    chk("err_pre", 32'(fl_if.fl_error), 0);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("err_set", 32'(fl_if.fl_error), 1);
    drive(2'b00, 2'b00, 0, 0, 1'b0);
    chk("err_hold", 32'(fl_if.fl_error), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
